// File: rtl/user_input_pkg.sv
// Shared types and width helpers for the user input conditioner.
package user_input_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Debounce counter must hold values up to DEBOUNCE_CYCLES.
  function automatic int deb_cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

  // Repeat counter must hold the larger of the initial delay and the period.
  function automatic int rep_cnt_width(input int repeat_delay, input int repeat_period);
    return (repeat_delay > repeat_period) ? $clog2(repeat_delay + 1)
                                          : $clog2(repeat_period + 1);
  endfunction

endpackage

// File: rtl/user_input_channel.sv
// One conditioner channel: synchroniser, debouncer, edge pulse and auto-repeat.
module user_input_channel
  import user_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Input,
  output logic Pulse,
  output logic Level
);

  localparam int DW = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = rep_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] REP_FIRST = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  localparam edge_mode_e MODE          = edge_mode_e'(EDGE_MODE);
  localparam bit         PULSE_ON_RISE = (MODE != EDGE_FALL);
  localparam bit         PULSE_ON_FALL = (MODE != EDGE_RISE);
  // Repeats only make sense when presses themselves produce pulses.
  localparam bit         REPEAT_EN     = (REPEAT_DELAY > 0) && PULSE_ON_RISE;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DW-1:0]          deb_cnt, deb_cnt_nxt;
  logic [RW-1:0]          rep_cnt, rep_cnt_nxt;
  logic                   level_nxt, pulse_nxt;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge Clock) begin
    if (Reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], Input};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Debounce acceptance, edge detection and repeat scheduling.
  always_comb begin
    deb_cnt_nxt = '0;
    level_nxt   = Level;
    pulse_nxt   = 1'b0;
    rep_cnt_nxt = rep_cnt;

    if (sync_s != Level) begin
      if (deb_cnt == DEB_LAST) level_nxt   = sync_s;
      else                     deb_cnt_nxt = deb_cnt + 1'b1;
    end

    // A Level transition takes precedence over a repeat that falls due the same cycle.
    if (level_nxt && !Level) begin
      pulse_nxt   = PULSE_ON_RISE;
      rep_cnt_nxt = REPEAT_EN ? REP_FIRST : '0;
    end else if (!level_nxt && Level) begin
      pulse_nxt   = PULSE_ON_FALL;
      rep_cnt_nxt = '0;
    end else if (REPEAT_EN && Level) begin
      if (rep_cnt == '0) begin
        pulse_nxt   = 1'b1;
        rep_cnt_nxt = REP_NEXT;
      end else begin
        rep_cnt_nxt = rep_cnt - 1'b1;
      end
    end else begin
      rep_cnt_nxt = '0;
    end
  end

  // Register channel state; reset clears everything without producing a pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      deb_cnt <= '0;
      rep_cnt <= '0;
      Level   <= 1'b0;
      Pulse   <= 1'b0;
    end else begin
      deb_cnt <= deb_cnt_nxt;
      rep_cnt <= rep_cnt_nxt;
      Level   <= level_nxt;
      Pulse   <= pulse_nxt;
    end
  end

endmodule

// File: rtl/user_input_conditioner.sv
// Multi-channel conditioner: N_CH fully independent copies of the channel block.
module user_input_conditioner
  import user_input_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = int'(EDGE_RISE),
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N_CH-1:0] Input,
  output logic [N_CH-1:0] Pulse,
  output logic [N_CH-1:0] Level
);

  // One conditioner per input bit; channels share nothing but clock and reset.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    user_input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .Clock(Clock),
      .Reset(Reset),
      .Input(Input[g]),
      .Pulse(Pulse[g]),
      .Level(Level[g])
    );
  end

endmodule

// File: tb/tb_user_input_conditioner.sv
// Bench for user_input_conditioner: several configurations driven by the same
// two-channel stimulus, compared against a window-based reference model.
module tb_user_input_conditioner;

  localparam int NI = 6;
  localparam int CFG_SYNC [NI] = '{2, 2, 2, 2, 2, 3};
  localparam int CFG_DEB  [NI] = '{4, 4, 4, 4, 4, 1};
  localparam int CFG_MODE [NI] = '{0, 0, 2, 1, 2, 0};
  localparam int CFG_DLY  [NI] = '{0, 8, 0, 0, 8, 3};
  localparam int CFG_PER  [NI] = '{4, 4, 4, 4, 4, 2};

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] in_a  = 2'b00;
  logic [1:0] pls [NI];
  logic [1:0] lvl [NI];

  always #5 Clock = ~Clock;

  user_input_conditioner #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(4)) u0 (.Clock(Clock), .Reset(Reset), .Input(in_a), .Pulse(pls[0]), .Level(lvl[0]));
  user_input_conditioner #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) u1 (.Clock(Clock), .Reset(Reset), .Input(in_a), .Pulse(pls[1]), .Level(lvl[1]));
  user_input_conditioner #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(4)) u2 (.Clock(Clock), .Reset(Reset), .Input(in_a), .Pulse(pls[2]), .Level(lvl[2]));
  user_input_conditioner #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(4)) u3 (.Clock(Clock), .Reset(Reset), .Input(in_a), .Pulse(pls[3]), .Level(lvl[3]));
  user_input_conditioner #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) u4 (.Clock(Clock), .Reset(Reset), .Input(in_a), .Pulse(pls[4]), .Level(lvl[4]));
  user_input_conditioner #(.N_CH(2), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0),
    .REPEAT_DELAY(3), .REPEAT_PERIOD(2)) u5 (.Clock(Clock), .Reset(Reset), .Input(in_a), .Pulse(pls[5]), .Level(lvl[5]));

  // Reference model state, indexed by instance*2 + channel.
  bit mq  [NI*2][$];   // raw input samples since reset
  bit msq [NI*2][$];   // synchronised values seen by the debouncer
  bit want_lvl [NI*2];
  bit want_pls [NI*2];
  int t0       [NI*2];
  int edge_n = 0;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Level flips once the last DEB synchronised samples all disagree with it;
  // the synchronised sample is simply the raw input SYNC edges earlier.
  task automatic model_edge(input bit rst, input logic [1:0] inp);
    edge_n++;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        int  x;
        bit  s, flip;
        x = i * 2 + c;
        if (rst) begin
          mq[x].delete();
          msq[x].delete();
          want_lvl[x] = 1'b0;
          want_pls[x] = 1'b0;
          t0[x]       = 0;
        end else begin
          s = (mq[x].size() >= CFG_SYNC[i]) ? mq[x][mq[x].size() - CFG_SYNC[i]] : 1'b0;
          msq[x].push_back(s);
          mq[x].push_back(inp[c]);
          flip = (msq[x].size() >= CFG_DEB[i]);
          for (int k = 0; k < CFG_DEB[i]; k++)
            if (flip && msq[x][msq[x].size() - 1 - k] == want_lvl[x]) flip = 1'b0;
          want_pls[x] = 1'b0;
          if (flip) begin
            want_lvl[x] = !want_lvl[x];
            if (want_lvl[x]) begin
              want_pls[x] = (CFG_MODE[i] != 1);
              t0[x]       = edge_n;
            end else begin
              want_pls[x] = (CFG_MODE[i] != 0);
            end
          end else if (want_lvl[x] && CFG_DLY[i] > 0 && CFG_MODE[i] != 1) begin
            int dt;
            dt = edge_n - t0[x];
            if (dt >= CFG_DLY[i] && ((dt - CFG_DLY[i]) % CFG_PER[i]) == 0) want_pls[x] = 1'b1;
          end
          while (mq[x].size() > 8)  void'(mq[x].pop_front());
          while (msq[x].size() > 8) void'(msq[x].pop_front());
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("u%0d.Pulse[%0d]@%0d", i, c, edge_n), pls[i][c], want_pls[i*2+c]);
        chk($sformatf("u%0d.Level[%0d]@%0d", i, c, edge_n), lvl[i][c], want_lvl[i*2+c]);
      end
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] inp);
    @(negedge Clock);
    Reset = rst;
    in_a  = inp;
    @(posedge Clock);
    model_edge(rst, inp);
    #1;
    check_all();
  endtask

  initial begin
    int cnt_a, cnt_b, p0, p1;
    int hold [2];
    logic [1:0] r;

    // Reset state
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    chk("reset pulse u0", pls[0], 2'b00);
    chk("reset level u0", lvl[0], 2'b00);

    // Press on channel 0: pulse after the sixth sampling edge, then release
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, (k <= 10) ? 2'b01 : 2'b00);
      if (k == 5) chk("t1 no pulse edge5", pls[0][0], 1'b0);
      if (k == 6) chk("t1 pulse edge6", pls[0][0], 1'b1);
      if (k == 7) chk("t1 pulse width", pls[0][0], 1'b0);
      if (pls[2][0]) cnt_a++;
      if (pls[3][0]) cnt_b++;
    end
    chk("t4 both-mode pulses", cnt_a, 2);
    chk("t4 fall-mode pulses", cnt_b, 1);

    // Short glitch is rejected, a 4-cycle stable high is accepted once
    cnt_a = 0;
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, (k <= 3) ? 2'b01 : 2'b00);
      if (pls[0][0] || lvl[0][0]) cnt_a++;
    end
    chk("t2 glitch ignored", cnt_a, 0);
    cnt_a = 0;
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, (k <= 4) ? 2'b01 : 2'b00);
      if (pls[0][0]) cnt_a++;
    end
    chk("t2 stable pulse count", cnt_a, 1);

    // Hold 30 cycles with repeat: pulses at t0, +8, +12, ... +28
    cnt_a = 0;
    for (int k = 1; k <= 42; k++) begin
      step(1'b0, (k <= 30) ? 2'b01 : 2'b00);
      if (pls[1][0]) cnt_a++;
    end
    chk("t3 repeat pulse count", cnt_a, 7);

    // Reset while a repeat is pending in both-edge mode
    for (int k = 1; k <= 12; k++) step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    chk("t5 reset pulse", pls[4][0], 1'b0);
    chk("t5 reset level", lvl[4][0], 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 2'b01);
      if (k == 5) chk("t5 no early pulse", pls[4][0], 1'b0);
      if (k == 6) chk("t5 pulse after redebounce", pls[4][0], 1'b1);
    end
    for (int k = 1; k <= 10; k++) step(1'b0, 2'b00);

    // Simultaneous presses, then channel 1 two cycles late
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, (k <= 10) ? 2'b11 : 2'b00);
      if (k == 6) chk("t6 simultaneous", pls[0], 2'b11);
    end
    p0 = -1; p1 = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, (k <= 2) ? 2'b01 : 2'b11);
      if (pls[0][0] && p0 < 0) p0 = k;
      if (pls[0][1] && p1 < 0) p1 = k;
    end
    chk("t6 first pulse edge", p0, 6);
    chk("t6 pulse spacing", p1 - p0, 2);
    for (int k = 1; k <= 10; k++) step(1'b0, 2'b00);

    // Randomised hold lengths with occasional reset
    hold[0] = 0; hold[1] = 0; r = 2'b00;
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          r[c]    = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 12);
        end
        hold[c]--;
      end
      step(($urandom_range(0, 59) == 0), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/user_input_conditioner.md
Name: user_input_conditioner

Overview:
- Multi-channel conditioner for asynchronous user inputs such as push-buttons and switches.
- Per channel: N-stage synchroniser, counter-based debouncer, then a single-cycle pulse generator with a selectable edge mode and optional hold-to-repeat.
- Sits between board I/O and game/control FSMs.
- Generalises the 2-flop, rising-edge, one-pulse input block to parametrised width, debounce and repeat.

Parameters:
- N_CH, 4: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flop depth; must be >=2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised value must differ from Level before it is accepted; must be >=1.
- EDGE_MODE, 0: 0 = pulse on rise, 1 = pulse on fall, 2 = pulse on both.
- REPEAT_DELAY, 0: cycles from the initial rise pulse to the first repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 4: cycles between subsequent repeat pulses; must be >=1.

Ports:
- Clock, input, 1: system clock; all state changes on the rising edge.
- Reset, input, 1: synchronous, active-high.
- Input, input, N_CH: raw asynchronous inputs, one bit per channel.
- Pulse, output, N_CH: one-cycle event strobe per channel.
- Level, output, N_CH: debounced, synchronised level per channel.

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock Clock.
- Channels are fully independent; no shared state.
- Reset:
  - Sync flops, Level, Pulse, debounce counter and repeat counter all clear to 0 on the edge where Reset=1.
  - Reset has priority over every other event.
  - Reset mid-operation never emits a Pulse, including Level dropping 1->0 in fall or both mode.
- Synchroniser:
  - Chain of SYNC_STAGES flops; s = last stage.
  - All stages reset to 0.
- Debounce counter:
  - Width $clog2(DEBOUNCE_CYCLES+1).
  - If s == Level: counter <= 0.
  - If s != Level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If s != Level and counter == DEBOUNCE_CYCLES-1: Level <= s, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles leaves Level and Pulse untouched; the counter restarts from 0.
- Latency:
  - Level and Pulse change after the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge that samples a stable new Input value.
  - Defaults give 6 edges.
- Pulse (registered, asserted the same cycle Level changes):
  - Rising Level transition: Pulse=1 in mode 0 or 2.
  - Falling Level transition: Pulse=1 in mode 1 or 2.
  - Otherwise Pulse=0, except for repeat pulses.
  - Pulse is never wider than 1 cycle.
- Auto-repeat:
  - Active only if REPEAT_DELAY > 0 and EDGE_MODE is 0 or 2.
  - On a rising Level transition, load the repeat counter with REPEAT_DELAY-1.
  - While Level=1: decrement each cycle; at 0, Pulse=1 and reload with REPEAT_PERIOD-1.
  - Repeat pulses fall at t0+REPEAT_DELAY, then every REPEAT_PERIOD, where t0 is the initial pulse cycle.
  - A falling Level transition clears the repeat counter and stops repeats immediately. The fall pulse in mode 2 still fires.
  - Repeat counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Level never changes other than through the debounce rule or Reset.
- Simultaneous activity on several channels produces simultaneous independent Pulse bits.

Decomposition:
- Package user_input_pkg holds:
  - edge_mode_e enum: EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
  - Width helper functions for the debounce and repeat counters.
- Sub-module user_input_channel: one channel (sync, debounce, edge, repeat), with the same parameters minus N_CH and 1-bit ports.
- Top instantiates N_CH copies in a generate loop; no other logic at top.

Test Plan:
All scenarios use defaults N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=0, REPEAT_DELAY=0 unless stated.
1. Reset 2 cycles, then Input[0] 0->1 and held -> Pulse[0]=1 for exactly 1 cycle after the 6th sampling edge; Level[0]=1 from that edge; Pulse[1] and Level[1] stay 0.
2. Input[0]=1 for 3 cycles, then back to 0 -> Level[0] and Pulse[0] remain 0 throughout; a later 4-cycle-stable high produces exactly one pulse.
3. REPEAT_DELAY=8, REPEAT_PERIOD=4, Input[0] held high 30 cycles -> pulses at t0, t0+8, t0+12, t0+16, t0+20, t0+24, t0+28; release -> no further pulses.
4. EDGE_MODE=2, press then release -> one pulse 6 edges after the rise and one pulse 6 edges after the fall. EDGE_MODE=1 instance -> pulse on the fall only.
5. Reset asserted while Level[0]=1 and a repeat is pending, in EDGE_MODE=2 -> Level and Pulse are 0 the next cycle with no pulse. After release of Reset with Input still 1, a full 6-edge debounce precedes the new pulse.
6. Both channels pressed on the same cycle, then channel 1 delayed 2 cycles -> simultaneous pulses in the first case; pulses exactly 2 cycles apart in the second.
